cla_pipelined_subtractor: RTL and testbench



---
 rtl/cla_pipelined_subtractor.sv | 119 +++++++++++
 tb/tb_cla_pipelined_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_subtractor.sv
// Two-stage pipelined add/subtract unit built from 4-bit carry-lookahead groups, valid/ready stream.
// Optional: define CLA_SUB_SATURATE_EN to clamp overflowing results to the signed limit.
module cla_pipelined_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             overflow
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / 4;

  // Half-width adder from 4-bit lookahead groups; group P/G chain the carry between groups.
  // Returns {carry_out, sum}.
  function automatic logic [H:0] cla_add(input logic [H-1:0] x,
                                         input logic [H-1:0] y,
                                         input logic         cin);
    logic [H-1:0] p, g, s;
    logic [3:0]   gp, gg;
    logic         c, c1, c2, c3, grp_p, grp_g;
    p = x ^ y;
    g = x & y;
    s = '0;
    c = cin;
    for (int k = 0; k < NG; k++) begin
      gp    = p[4*k +: 4];
      gg    = g[4*k +: 4];
      c1    = gg[0] | (gp[0] & c);
      c2    = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
      c3    = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c);
      grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
      grp_p = &gp;
      s[4*k +: 4] = gp ^ {c3, c2, c1, c};
      c = grp_g | (grp_p & c);
    end
    return {c, s};
  endfunction

  logic             r_v1, r_v2;
  logic [H-1:0]     r_lo_sum, r_a_hi, r_b_hi;
  logic             r_c_mid, r_op_sub;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_ovf;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic [H:0]       w_lo, w_hi;
  logic             w_ovf, w_carry;
  logic [WIDTH-1:0] w_res;

  // A single advance enable: the whole pipe moves or the whole pipe holds.
  assign w_en     = !r_v2 || out_ready;
  assign in_ready = w_en;

  // Subtraction is a + ~b + 1: invert b and force the carry-in to 1.
  assign w_b_eff = op_sub ? ~b : b;
  assign w_lo    = cla_add(a[H-1:0], w_b_eff[H-1:0], op_sub);

  assign w_hi    = cla_add(r_a_hi, r_b_hi, r_c_mid);
  assign w_carry = r_op_sub ? ~w_hi[H] : w_hi[H];
  assign w_ovf   = (r_a_hi[H-1] == r_b_hi[H-1]) && (w_hi[H-1] != r_a_hi[H-1]);

`ifdef CLA_SUB_SATURATE_EN
  always_comb begin
    w_res = {w_hi[H-1:0], r_lo_sum};
    if (w_ovf)
      w_res = r_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_res = {w_hi[H-1:0], r_lo_sum};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_lo_sum <= '0;
      r_c_mid  <= 1'b0;
      r_a_hi   <= '0;
      r_b_hi   <= '0;
      r_op_sub <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_lo_sum <= w_lo[H-1:0];
        r_c_mid  <= w_lo[H];
        r_a_hi   <= a[WIDTH-1:H];
        r_b_hi   <= w_b_eff[WIDTH-1:H];
        r_op_sub <= op_sub;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_result <= w_res;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign out_valid  = r_v2;
  assign result     = r_result;
  assign carry_flag = r_carry;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Directed-vector bench for cla_pipelined_subtractor (16-bit); inputs driven and outputs sampled on negedge.
module tb_cla_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        carry_flag, overflow;

  int errors = 0;
  int checks = 0;

  cla_pipelined_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_flag(carry_flag), .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef CLA_SUB_SATURATE_EN
  localparam logic [15:0] SUB_OVF_RES = 16'h8000;
  localparam logic [15:0] ADD_OVF_RES = 16'h7FFF;
`else
  localparam logic [15:0] SUB_OVF_RES = 16'h7FFF;
  localparam logic [15:0] ADD_OVF_RES = 16'h8000;
`endif

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    checks++;
    if ({out_valid, result, carry_flag, overflow} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h c=%b o=%b want all 0", out_valid, result, carry_flag, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  // One isolated operation: out_valid must be low one edge after accept and high exactly two edges after.
  task automatic run_op(input string name, input logic sub, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp_r, input logic exp_c, input logic exp_o);
    @(negedge clk);
    in_valid = 1'b1; op_sub = sub; a = x; b = y; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency1: out_valid=%b want 0", name, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== exp_r || carry_flag !== exp_c || overflow !== exp_o) begin
      errors++;
      $display("FAIL %s: got v=%b r=%h c=%b o=%b want v=1 r=%h c=%b o=%b",
               name, out_valid, result, carry_flag, overflow, exp_r, exp_c, exp_o);
    end
  endtask

  task automatic test_arith();
    run_op("sub_5_3",      1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    run_op("sub_3_5",      1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    run_op("sub_0_0",      1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("sub_8000_1",   1'b1, 16'h8000, 16'h0001, SUB_OVF_RES, 1'b0, 1'b1);
    run_op("add_7fff_1",   1'b0, 16'h7FFF, 16'h0001, ADD_OVF_RES, 1'b0, 1'b1);
    run_op("add_ffff_1",   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("sub_0100_1",   1'b1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
    run_op("add_00ff_1",   1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000};
    logic [15:0] vr [6] = '{16'h0FFF, 16'h2001, 16'h2FFF, 16'h4001, 16'h4FFF, 16'h6001};
    int sent = 0;
    int got = 0;
    int dup = 0;
    logic [15:0] held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 6);
      op_sub    = (sent % 2 == 0);
      a         = va[sent % 6];
      b         = 16'h0001;
      #1;
      if (cyc == 4) held = result;
      if (cyc >= 4 && cyc < 7) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== held) begin
          errors++;
          $display("FAIL stall_cyc%0d: in_ready=%b out_valid=%b result=%h want 0/1/%h",
                   cyc, in_ready, out_valid, result, held);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (result !== vr[got] || carry_flag !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL stream_%0d: got r=%h c=%b o=%b want r=%h c=0 o=0",
                   got, result, carry_flag, overflow, vr[got]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 6 || sent !== 6) begin
      errors++;
      $display("FAIL stream_count: got=%0d sent=%0d want 6/6", got, sent);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) dup++;
    end
    checks++;
    if (dup !== 0) begin
      errors++;
      $display("FAIL stream_dup: extra valid cycles=%0d want 0", dup);
    end
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; op_sub = 1'b1; a = 16'h0009; b = 16'h0002;
    @(negedge clk); a = 16'h0030; b = 16'h0010;
    @(negedge clk); in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_prefill: out_valid=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, carry_flag, overflow} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_async: got v=%b r=%h c=%b o=%b want all 0", out_valid, result, carry_flag, overflow);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_stale: stale valid cycles=%0d in_ready=%b want 0/1", stale, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
